// File: rtl/axil_pkg.sv
// Shared AXI-Lite slice definitions: per-channel stage modes and response codes.
package axil_pkg;

  localparam int REG_BYPASS = 0;
  localparam int REG_SIMPLE = 1;
  localparam int REG_SKID   = 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_reg_stage.sv
// Generic valid/ready register stage: bypass, single register, or main+skid register pair.
module axil_reg_stage
  import axil_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_TYPE = REG_SIMPLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  if (REG_TYPE == REG_SKID) begin : g_skid
    logic [WIDTH-1:0] main_q, skid_q;
    logic             main_vld_q, skid_vld_q, rdy_q;
    logic             in_xfer;

    assign in_xfer = s_valid & rdy_q;
    assign s_ready = rdy_q;
    assign m_valid = main_vld_q;
    assign m_data  = main_q;

    // Ready only drops when a beat lands in skid, so it never depends on m_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        main_q     <= '0;
        skid_q     <= '0;
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
        rdy_q      <= 1'b0;
      end else if (skid_vld_q) begin
        if (m_ready) begin
          main_q     <= skid_q;
          skid_vld_q <= 1'b0;
          rdy_q      <= 1'b1;
        end
      end else begin
        rdy_q <= 1'b1;
        if (in_xfer && main_vld_q && !m_ready) begin
          skid_q     <= s_data;
          skid_vld_q <= 1'b1;
          rdy_q      <= 1'b0;
        end else if (in_xfer) begin
          main_q     <= s_data;
          main_vld_q <= 1'b1;
        end else if (main_vld_q && m_ready) begin
          main_vld_q <= 1'b0;
        end
      end
    end
  end else if (REG_TYPE == REG_SIMPLE) begin : g_simple
    logic [WIDTH-1:0] data_q;
    logic             vld_q, rdy_q;
    logic             in_xfer;

    assign in_xfer = s_valid & rdy_q;
    assign s_ready = rdy_q;
    assign m_valid = vld_q;
    assign m_data  = data_q;

    // Ready is registered as "empty next cycle" so it reads 0 in reset and 1 after the first edge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q <= '0;
        vld_q  <= 1'b0;
        rdy_q  <= 1'b0;
      end else if (in_xfer) begin
        data_q <= s_data;
        vld_q  <= 1'b1;
        rdy_q  <= 1'b0;
      end else if (vld_q && m_ready) begin
        vld_q <= 1'b0;
        rdy_q <= 1'b1;
      end else begin
        rdy_q <= ~vld_q;
      end
    end
  end else begin : g_bypass
    assign s_ready = m_ready;
    assign m_valid = s_valid;
    assign m_data  = s_data;
  end

endmodule

// File: rtl/axil_reg_slice.sv
// AXI-Lite register slice: five independent channel stages, each with its own mode.
// DATA_WIDTH is expected to be 8, 16, 32 or 64.
module axil_reg_slice
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int AW_REG_TYPE = REG_SIMPLE,
  parameter int W_REG_TYPE  = REG_SIMPLE,
  parameter int B_REG_TYPE  = REG_SIMPLE,
  parameter int AR_REG_TYPE = REG_SIMPLE,
  parameter int R_REG_TYPE  = REG_SKID
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  axil_reg_stage #(.WIDTH(ADDR_WIDTH + 3), .REG_TYPE(AW_REG_TYPE)) u_aw (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({s_axil_awprot, s_axil_awaddr}),
    .s_valid (s_axil_awvalid),
    .s_ready (s_axil_awready),
    .m_data  ({m_axil_awprot, m_axil_awaddr}),
    .m_valid (m_axil_awvalid),
    .m_ready (m_axil_awready)
  );

  axil_reg_stage #(.WIDTH(DATA_WIDTH + STRB_WIDTH), .REG_TYPE(W_REG_TYPE)) u_w (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({s_axil_wstrb, s_axil_wdata}),
    .s_valid (s_axil_wvalid),
    .s_ready (s_axil_wready),
    .m_data  ({m_axil_wstrb, m_axil_wdata}),
    .m_valid (m_axil_wvalid),
    .m_ready (m_axil_wready)
  );

  // Response channels flow master-to-slave, so the stage's upstream side is m_axil_*.
  axil_reg_stage #(.WIDTH(2), .REG_TYPE(B_REG_TYPE)) u_b (
    .clk     (clk),
    .rst     (rst),
    .s_data  (m_axil_bresp),
    .s_valid (m_axil_bvalid),
    .s_ready (m_axil_bready),
    .m_data  (s_axil_bresp),
    .m_valid (s_axil_bvalid),
    .m_ready (s_axil_bready)
  );

  axil_reg_stage #(.WIDTH(ADDR_WIDTH + 3), .REG_TYPE(AR_REG_TYPE)) u_ar (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({s_axil_arprot, s_axil_araddr}),
    .s_valid (s_axil_arvalid),
    .s_ready (s_axil_arready),
    .m_data  ({m_axil_arprot, m_axil_araddr}),
    .m_valid (m_axil_arvalid),
    .m_ready (m_axil_arready)
  );

  axil_reg_stage #(.WIDTH(DATA_WIDTH + 2), .REG_TYPE(R_REG_TYPE)) u_r (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({m_axil_rresp, m_axil_rdata}),
    .s_valid (m_axil_rvalid),
    .s_ready (m_axil_rready),
    .m_data  ({s_axil_rresp, s_axil_rdata}),
    .m_valid (s_axil_rvalid),
    .m_ready (s_axil_rready)
  );

endmodule

// File: tb/tb_axil_reg_slice.sv
// Directed bench: default-mode slice (AW/W/B/AR simple, R skid) plus an all-bypass slice.
module tb_axil_reg_slice;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // default-mode DUT signals
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  s_awprot, s_arprot, m_awprot, m_arprot;
  logic [3:0]  s_wstrb, m_wstrb;
  logic [1:0]  s_bresp, s_rresp, m_bresp, m_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  // bypass DUT signals
  logic [31:0] bs_awaddr, bs_araddr, bs_wdata, bs_rdata, bm_awaddr, bm_araddr, bm_wdata, bm_rdata;
  logic [2:0]  bs_awprot, bs_arprot, bm_awprot, bm_arprot;
  logic [3:0]  bs_wstrb, bm_wstrb;
  logic [1:0]  bs_bresp, bs_rresp, bm_bresp, bm_rresp;
  logic bs_awvalid, bs_awready, bs_wvalid, bs_wready, bs_bvalid, bs_bready;
  logic bs_arvalid, bs_arready, bs_rvalid, bs_rready;
  logic bm_awvalid, bm_awready, bm_wvalid, bm_wready, bm_bvalid, bm_bready;
  logic bm_arvalid, bm_arready, bm_rvalid, bm_rready;

  axil_reg_slice dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
    .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
    .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
    .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
    .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
  );

  axil_reg_slice #(
    .AW_REG_TYPE(0), .W_REG_TYPE(0), .B_REG_TYPE(0), .AR_REG_TYPE(0), .R_REG_TYPE(0)
  ) dut_byp (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(bs_awaddr), .s_axil_awprot(bs_awprot), .s_axil_awvalid(bs_awvalid), .s_axil_awready(bs_awready),
    .s_axil_wdata(bs_wdata), .s_axil_wstrb(bs_wstrb), .s_axil_wvalid(bs_wvalid), .s_axil_wready(bs_wready),
    .s_axil_bresp(bs_bresp), .s_axil_bvalid(bs_bvalid), .s_axil_bready(bs_bready),
    .s_axil_araddr(bs_araddr), .s_axil_arprot(bs_arprot), .s_axil_arvalid(bs_arvalid), .s_axil_arready(bs_arready),
    .s_axil_rdata(bs_rdata), .s_axil_rresp(bs_rresp), .s_axil_rvalid(bs_rvalid), .s_axil_rready(bs_rready),
    .m_axil_awaddr(bm_awaddr), .m_axil_awprot(bm_awprot), .m_axil_awvalid(bm_awvalid), .m_axil_awready(bm_awready),
    .m_axil_wdata(bm_wdata), .m_axil_wstrb(bm_wstrb), .m_axil_wvalid(bm_wvalid), .m_axil_wready(bm_wready),
    .m_axil_bresp(bm_bresp), .m_axil_bvalid(bm_bvalid), .m_axil_bready(bm_bready),
    .m_axil_araddr(bm_araddr), .m_axil_arprot(bm_arprot), .m_axil_arvalid(bm_arvalid), .m_axil_arready(bm_arready),
    .m_axil_rdata(bm_rdata), .m_axil_rresp(bm_rresp), .m_axil_rvalid(bm_rvalid), .m_axil_rready(bm_rready)
  );

  task automatic check_readies(input string tag, input logic exp);
    check({tag, "_awready"}, s_awready, exp);
    check({tag, "_wready"},  s_wready,  exp);
    check({tag, "_bready"},  m_bready,  exp);
    check({tag, "_arready"}, s_arready, exp);
    check({tag, "_rready"},  m_rready,  exp);
  endtask

  task automatic check_valids(input string tag);
    check({tag, "_awvalid"}, m_awvalid, 1'b0);
    check({tag, "_wvalid"},  m_wvalid,  1'b0);
    check({tag, "_bvalid"},  s_bvalid,  1'b0);
    check({tag, "_arvalid"}, m_arvalid, 1'b0);
    check({tag, "_rvalid"},  s_rvalid,  1'b0);
    check({tag, "_rdata"},   s_rdata,   32'h0);
  endtask

  initial begin
    int idx;
    int exp_r;
    int src;
    logic mx;

    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0; m_arready = 0;
    m_rdata = '0; m_rresp = '0; m_rvalid = 0;
    bs_awaddr = '0; bs_awprot = '0; bs_awvalid = 0; bs_wdata = '0; bs_wstrb = '0; bs_wvalid = 0;
    bs_bready = 0; bs_araddr = '0; bs_arprot = '0; bs_arvalid = 0; bs_rready = 0;
    bm_awready = 0; bm_wready = 0; bm_bresp = '0; bm_bvalid = 0; bm_arready = 0;
    bm_rdata = '0; bm_rresp = '0; bm_rvalid = 0;

    // reset state
    #2;
    check_valids("rst0");
    check_readies("rst0", 1'b0);
    repeat (2) @(negedge clk);
    check_readies("rst_hold", 1'b0);
    rst = 1'b1;
    #1 check("rst_rel_awready", s_awready, 1'b0);
    @(negedge clk);
    check_readies("post_rst", 1'b1);

    // single write through simple stages, then OKAY response
    s_awaddr = 32'h0000_1000; s_awprot = 3'b010; s_awvalid = 1;
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1;
    m_awready = 1; m_wready = 1;
    check("wr_m_awvalid_pre", m_awvalid, 1'b0);
    @(negedge clk);
    check("wr_m_awvalid", m_awvalid, 1'b1);
    check("wr_m_awaddr", m_awaddr, 32'h0000_1000);
    check("wr_m_awprot", m_awprot, 3'b010);
    check("wr_m_wvalid", m_wvalid, 1'b1);
    check("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("wr_m_wstrb", m_wstrb, 4'hF);
    check("wr_s_awready_full", s_awready, 1'b0);
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    check("wr_m_awvalid_done", m_awvalid, 1'b0);
    check("wr_s_awready_back", s_awready, 1'b1);
    m_bresp = 2'b00; m_bvalid = 1; s_bready = 1;
    check("b_s_bvalid_pre", s_bvalid, 1'b0);
    @(negedge clk);
    check("b_s_bvalid", s_bvalid, 1'b1);
    check("b_s_bresp", s_bresp, 2'b00);
    check("b_m_bready_full", m_bready, 1'b0);
    m_bvalid = 0;
    @(negedge clk);
    check("b_s_bvalid_done", s_bvalid, 1'b0);

    // R skid: 16-beat burst at one beat per cycle
    s_rready = 1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check("burst_rvalid", s_rvalid, 1'b1);
        check("burst_rdata", s_rdata, 32'(k - 1));
      end
      if (k < 16) begin
        check("burst_m_rready", m_rready, 1'b1);
        m_rvalid = 1; m_rdata = 32'(k); m_rresp = 2'b00;
      end else begin
        m_rvalid = 0;
      end
    end
    @(negedge clk);
    check("burst_idle", s_rvalid, 1'b0);

    // R skid: downstream stall for three cycles mid-burst
    exp_r = 100; src = 100; mx = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mx) src++;
      m_rvalid = (src < 110);
      m_rdata  = 32'(src);
      m_rresp  = (src == 105) ? 2'b11 : 2'b00;
      s_rready = !(c >= 3 && c <= 5);
      mx = m_rvalid && m_rready;
      if (s_rvalid) begin
        check("stall_rdata", s_rdata, 32'(exp_r));
        check("stall_rresp", s_rresp, (exp_r == 105) ? 2'b11 : 2'b00);
        if (s_rready) exp_r++;
      end
      if (c == 4 || c == 5) check("stall_m_rready_low", m_rready, 1'b0);
      if (c == 7) check("stall_m_rready_back", m_rready, 1'b1);
    end
    check("stall_beats_all", 32'(exp_r), 32'd110);
    check("stall_idle", s_rvalid, 1'b0);

    // AR simple: continuous arvalid, one acceptance every two cycles
    m_arready = 1; idx = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 6) check("ar_s_arready", s_arready, (c % 2) == 0);
      check("ar_m_arvalid", m_arvalid, (c % 2) == 1);
      if (c % 2 == 1) check("ar_m_araddr", m_araddr, 32'((c / 2) * 4));
      s_arvalid = (idx < 3);
      s_araddr  = 32'(idx * 4);
      if (s_arvalid && s_arready) idx++;
    end
    s_arvalid = 0;
    check("ar_count", 32'(idx), 32'd3);

    // reset asserted with R skid full
    s_rready = 0;
    @(negedge clk);
    m_rvalid = 1; m_rdata = 32'hA1;
    @(negedge clk);
    m_rdata = 32'hA2;
    @(negedge clk);
    m_rvalid = 0;
    check("skid_full_m_rready", m_rready, 1'b0);
    check("skid_full_rdata", s_rdata, 32'hA1);
    #2 rst = 1'b0;
    #1;
    check_valids("mid_rst");
    check_readies("mid_rst", 1'b0);
    @(negedge clk);
    check_readies("mid_rst_hold", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_readies("re_rst", 1'b1);
    check("re_rst_rvalid", s_rvalid, 1'b0);

    // all-bypass slice: combinational pass-through
    bs_awaddr = 32'h1234_5678; bs_awprot = 3'b101; bs_awvalid = 1; bm_awready = 1;
    bs_wdata = 32'hCAFE_F00D; bs_wstrb = 4'hA; bs_wvalid = 1; bm_wready = 0;
    bm_bresp = 2'b10; bm_bvalid = 1; bs_bready = 0;
    bs_araddr = 32'h0000_0ABC; bs_arprot = 3'b011; bs_arvalid = 1; bm_arready = 1;
    bm_rdata = 32'h5555_AAAA; bm_rresp = 2'b11; bm_rvalid = 1; bs_rready = 1;
    #1;
    check("byp_awaddr", bm_awaddr, 32'h1234_5678);
    check("byp_awprot", bm_awprot, 3'b101);
    check("byp_awvalid", bm_awvalid, 1'b1);
    check("byp_awready", bs_awready, 1'b1);
    check("byp_wdata", bm_wdata, 32'hCAFE_F00D);
    check("byp_wstrb", bm_wstrb, 4'hA);
    check("byp_wready", bs_wready, 1'b0);
    check("byp_bresp", bs_bresp, 2'b10);
    check("byp_bvalid", bs_bvalid, 1'b1);
    check("byp_bready", bm_bready, 1'b0);
    check("byp_araddr", bm_araddr, 32'h0000_0ABC);
    check("byp_arprot", bm_arprot, 3'b011);
    check("byp_rdata", bs_rdata, 32'h5555_AAAA);
    check("byp_rresp", bs_rresp, 2'b11);
    check("byp_rready", bm_rready, 1'b1);
    bs_awvalid = 0; bm_wready = 1; bm_bresp = 2'b01;
    #1;
    check("byp_awvalid_low", bm_awvalid, 1'b0);
    check("byp_wready_high", bs_wready, 1'b1);
    check("byp_bresp_exok", bs_bresp, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_slice.md
AXIL_REG_SLICE -- requirements
Module: axil_reg_slice

Interface
REQ-001 SHALL be parametrised by ADDR_WIDTH, default 32, address width of AW and AR.
REQ-002 SHALL be parametrised by DATA_WIDTH, default 32, data width of W and R; only 8/16/32/64 legal.
REQ-003 SHALL be parametrised by STRB_WIDTH, default DATA_WIDTH/8, W strobe width.
REQ-004 SHALL be parametrised by AW_REG_TYPE, default 1, AW stage mode (0 bypass, 1 simple, 2 skid).
REQ-005 SHALL be parametrised by W_REG_TYPE, default 1, W stage mode.
REQ-006 SHALL be parametrised by B_REG_TYPE, default 1, B stage mode.
REQ-007 SHALL be parametrised by AR_REG_TYPE, default 1, AR stage mode.
REQ-008 SHALL be parametrised by R_REG_TYPE, default 2, R stage mode.
REQ-009 SHALL provide clk  in  1  single clock; all logic rising-edge.
REQ-010 SHALL provide rst  in  1  asynchronous, active-low reset.
REQ-011 SHALL provide s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1, s_axil_awready  out  1; slave write-address channel.
REQ-012 SHALL provide s_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1, s_axil_wready  out  1; slave write-data channel.
REQ-013 SHALL provide s_axil_bresp/bvalid  out  2/1, s_axil_bready  in  1; slave write-response channel.
REQ-014 SHALL provide s_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1, s_axil_arready  out  1; slave read-address channel.
REQ-015 SHALL provide s_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1, s_axil_rready  in  1; slave read-data channel.
REQ-016 SHALL provide m_axil_* mirror of REQ-011..015 with directions reversed; master side.

Function
REQ-017 SHALL treat each of the five channels as an independent valid/ready stage; no cross-channel ordering or coupling.
REQ-018 SHALL, in mode 0, connect payload, valid and ready combinationally; latency 0, no state.
REQ-019 SHALL, in mode 1, hold one payload register; upstream ready = stage empty; latency 1 cycle; max throughput one beat per 2 cycles.
REQ-020 SHALL, in mode 2, hold main and skid registers; upstream ready registered, = skid empty; latency 1 cycle; sustained throughput 1 beat/cycle under continuous downstream ready.
REQ-021 SHALL, in mode 2, capture a beat into skid when upstream transfers while main is full and downstream stalls; on next downstream transfer, skid moves to main and ready reasserts next cycle.
REQ-022 SHALL, in modes 1/2, drive downstream valid and payload purely from registers; no combinational path ready->valid or valid->ready across the stage.
REQ-023 SHALL hold downstream payload stable while valid high and ready low (AXI rule).
REQ-024 SHALL never drop, duplicate or reorder beats within a channel.
REQ-025 SHALL, on simultaneous upstream and downstream transfer with main full and skid empty, load main with the new beat in the same edge.
REQ-026 SHALL pass bresp/rresp values unmodified, including SLVERR and DECERR.

Reset
REQ-027 SHALL, while rst low, clear all valid registers, drive all m_*valid and s_*valid outputs 0, payload outputs 0.
REQ-028 SHALL drive registered ready outputs 0 during reset and 1 from the first rising clk edge after rst deasserts.
REQ-029 SHALL discard any in-flight beat on reset assertion mid-transfer; no partial state survives.

Structure
REQ-030 SHALL take mode constants REG_BYPASS=0, REG_SIMPLE=1, REG_SKID=2 and response codes OKAY/EXOKAY/SLVERR/DECERR from shared package axil_pkg.
REQ-031 SHALL implement one generic sub-module axil_reg_stage (parameters WIDTH, REG_TYPE), instantiated five times with concatenated payloads.

Verification
REQ-032 Bench SHALL cover: all modes 1, single write awaddr=32'h0000_1000, wdata=32'hDEAD_BEEF, wstrb=4'hF -> m_ side presents identical values 1 cycle later, bresp=2'b00 returned 1 cycle after m_axil_bvalid.
REQ-033 Bench SHALL cover: R mode 2, m_axil_rvalid held high 16 cycles with rdata 0..15, s_axil_rready=1 -> s_ side sees 0..15 in order, 1 beat/cycle.
REQ-034 Bench SHALL cover: R mode 2, s_axil_rready dropped for 3 cycles mid-burst -> m_axil_rready low after skid fills, no beat lost, rdata stable while stalled.
REQ-035 Bench SHALL cover: AR mode 1, continuous arvalid with araddr 0x0,0x4,0x8 -> one acceptance every 2 cycles, addresses in order.
REQ-036 Bench SHALL cover: all modes 0 -> m_ outputs equal s_ inputs same cycle; bresp=2'b10 passes unchanged.
REQ-037 Bench SHALL cover: rst driven low with skid full -> all valids 0 asynchronously, readies 0, readies 1 at first edge after release.
